// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional two's-complement mode,
// start/busy/done handshake and divide-by-zero flag. Results are held until the next completion.
module seq_divider #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             dbz_q, dbz_d;

  logic             sm, accept, fit;
  logic [WIDTH-1:0] a_mag, b_mag, rem_nx, quo_nx;
  logic [WIDTH:0]   shifted;

  always_comb begin
    sm     = SIGNED_EN && signed_mode;
    accept = start && (state_q != CALC);
    a_mag  = (sm && dividend[WIDTH-1])   ? -dividend   : dividend;
    b_mag  = (sm && divisor_in[WIDTH-1]) ? -divisor_in : divisor_in;

    // When the trial subtraction fits, the difference is below the divisor,
    // so WIDTH-bit modular subtraction gives the exact partial remainder.
    shifted = {rem_q, quo_q[WIDTH-1]};
    fit     = shifted >= {1'b0, dvs_q};
    rem_nx  = fit ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], fit};

    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          q_d     = negq_q ? -quo_nx : quo_nx;
          r_d     = negr_q ? -rem_nx : rem_nx;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          dbz_d  = 1'b0;
          negq_d = sm && (dividend[WIDTH-1] ^ divisor_in[WIDTH-1]);
          negr_d = sm && dividend[WIDTH-1];
          if (divisor_in == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            cnt_d   = CW'(WIDTH-1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=8, SIGNED_EN=1): directed cases plus random operands,
// compared against an integer-arithmetic reference.
module tb_seq_divider;
  logic       clk = 1'b0;
  logic       rst, start, signed_mode;
  logic [7:0] dividend, divisor_in;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor_in(divisor_in),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {dbz, quotient, remainder}; SV integer division truncates toward zero.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int sa, sb, q, r;
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, q[7:0], r[7:0]};
  endfunction

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Called at a negedge with the divider not busy; returns at the negedge where done is seen.
  // intr>0 pulses a competing start (9/3) on that edge index after acceptance.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input int intr, input string tag);
    logic [16:0] exp;
    int          n, nbusy;
    bit          seen;
    exp = model(a, b, sm);
    start = 1'b1; dividend = a; divisor_in = b; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'($urandom); divisor_in = 8'($urandom); signed_mode = 1'($urandom);
    n = 1; nbusy = 0; seen = 0;
    while (n < 40) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nbusy++;
      if (intr != 0 && n == intr) begin
        start = 1'b1; dividend = 8'd9; divisor_in = 8'd3; signed_mode = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk($sformatf("%s_done", tag), 32'(seen), 32'd1);
    chk($sformatf("%s_lat", tag), n, (b == 8'd0) ? 32'd1 : 32'd9);
    chk($sformatf("%s_busycyc", tag), nbusy, (b == 8'd0) ? 32'd0 : 32'd8);
    chk($sformatf("%s_busy_at_done", tag), 32'(busy), 32'd0);
    chk($sformatf("%s_q", tag), 32'(quotient), 32'(exp[15:8]));
    chk($sformatf("%s_r", tag), 32'(remainder), 32'(exp[7:0]));
    chk($sformatf("%s_dbz", tag), 32'(div_by_zero), 32'(exp[16]));
  endtask

  initial begin
    bit         seen;
    logic [7:0] ra, rb;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor_in = '0;
    idle(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    idle(1);

    do_op(8'd200, 8'd7, 1'b0, 0, "u200_7");
    idle(2);
    do_op(8'd6, 8'd2, 1'b0, 0, "u6_2");
    do_op(8'd7, 8'd2, 1'b0, 0, "u7_2_b2b");
    idle(1);
    do_op(8'd13, 8'd0, 1'b0, 0, "u13_0");
    do_op(8'd10, 8'd3, 1'b0, 0, "u10_3_after_dbz");
    do_op(8'hF9, 8'd2, 1'b1, 0, "s_m7_2");
    do_op(8'd7, 8'hFE, 1'b1, 0, "s_7_m2");
    do_op(8'h80, 8'hFF, 1'b1, 0, "s_ovf");
    do_op(8'hF9, 8'd0, 1'b1, 0, "s_dbz");
    do_op(8'hF9, 8'd2, 1'b0, 0, "u249_2");
    do_op(8'd255, 8'd255, 1'b0, 0, "u255_255");
    do_op(8'd0, 8'd5, 1'b0, 0, "u0_5");
    do_op(8'h7F, 8'hFF, 1'b1, 0, "s_127_m1");
    do_op(8'h80, 8'd1, 1'b1, 0, "s_m128_1");
    do_op(8'd50, 8'd5, 1'b0, 3, "u50_5_ignored");

    // Reset in the middle of a division: outputs clear at once, nothing completes.
    idle(1);
    start = 1'b1; dividend = 8'd255; divisor_in = 8'd1; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_q", 32'(quotient), 32'd0);
    chk("midrst_r", 32'(remainder), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("midrst_no_activity", 32'(seen), 32'd0);
    do_op(8'd9, 8'd4, 1'b0, 0, "u9_4_after_rst");

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      do_op(ra, rb, 1'($urandom), 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
